// File: rtl/dbginit_mon_pkg.sv
// Shared types and helpers for the multi-channel DBGINIT reset-value monitor.
package dbginit_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic MODE_STRICT = 1'b0;
    localparam logic MODE_WINDOW = 1'b1;
    localparam int   POP_W       = 6;

    function automatic logic [POP_W-1:0] popcount32(input logic [31:0] vec);
        logic [POP_W-1:0] cnt;
        cnt = {POP_W{1'b0}};
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {{(POP_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Adds inc to acc, clamping at max instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] acc,
                                             input logic [31:0] inc,
                                             input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum > {1'b0, max}) begin
            return max;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/dbginit_chan_chk.sv
// Per-channel checker: remembers the pre-dbginit match and any in-window match,
// and evaluates the channel verdict on the shared check strobe.
module dbginit_chan_chk
    import dbginit_mon_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] actual_i,
    input  logic [W-1:0] expected_i,
    input  logic         chan_en_i,
    input  logic         mode_i,
    input  logic         latch_pre_i,
    input  logic         clr_seen_i,
    input  logic         count_active_i,
    input  logic         check_i,
    output logic         fail_o,
    output logic         unchanged_o
);

    logic match_s;
    logic pre_match_q;
    logic seen_match_q;

    assign match_s = (actual_i == expected_i);

    // Pre-dbginit match snapshot and sticky window match.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_match_q  <= 1'b0;
            seen_match_q <= 1'b0;
        end else begin
            if (latch_pre_i) begin
                pre_match_q <= match_s;
            end
            if (clr_seen_i) begin
                seen_match_q <= 1'b0;
            end else if (count_active_i && match_s) begin
                seen_match_q <= 1'b1;
            end
        end
    end

    // Verdict is only meaningful on the check cycle of an enabled channel.
    always_comb begin
        fail_o      = 1'b0;
        unchanged_o = 1'b0;
        if (check_i && chan_en_i) begin
            if (mode_i == MODE_WINDOW) begin
                fail_o = ~(seen_match_q | match_s);
            end else begin
                fail_o = ~match_s;
            end
            unchanged_o = pre_match_q & match_s;
        end else begin
            fail_o      = 1'b0;
            unchanged_o = 1'b0;
        end
    end

endmodule

// File: rtl/dbginit_multi_mon.sv
// Multi-channel DBGINIT monitor: shared round sequencer, delay counter and
// aggregation of per-channel verdicts into sticky/saturating results.
module dbginit_multi_mon
    import dbginit_mon_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int W     = 16,
    parameter int CNT_W = 11,
    parameter int ERR_W = 8,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             dbginit_i,
    input  logic             mode_i,
    input  logic [NCH-1:0]   chan_en_i,
    input  logic [CNT_W-1:0] cnt_val_i,
    input  logic [NCH*W-1:0] actual_i,
    input  logic [NCH*W-1:0] expected_i,
    output logic             done_o,
    output logic             pass_o,
    output logic [NCH-1:0]   fail_vec_o,
    output logic [NCH-1:0]   unchanged_vec_o,
    output logic             fail_pulse_o,
    output logic             first_fail_valid_o,
    output logic [IDX_W-1:0] first_fail_idx_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam logic [31:0] ERR_MAX32 = 32'((64'd1 << ERR_W) - 64'd1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cntr_q, cntr_d;
    logic             latch_pre_s, clr_seen_s, count_active_s, check_s, leave_done_s;
    logic [NCH-1:0]   fail_s, unch_s;
    logic [IDX_W-1:0] low_idx_s;
    logic [ERR_W-1:0] err_next_s;

    logic             done_q, pass_q, fail_pulse_q, ffv_q;
    logic [NCH-1:0]   fail_vec_q, unch_q;
    logic [IDX_W-1:0] ffi_q;
    logic [ERR_W-1:0] err_q;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        dbginit_chan_chk #(.W(W)) u_chk (
            .clk            (clk),
            .rst            (rst),
            .actual_i       (actual_i[g*W +: W]),
            .expected_i     (expected_i[g*W +: W]),
            .chan_en_i      (chan_en_i[g]),
            .mode_i         (mode_i),
            .latch_pre_i    (latch_pre_s),
            .clr_seen_i     (clr_seen_s),
            .count_active_i (count_active_s),
            .check_i        (check_s),
            .fail_o         (fail_s[g]),
            .unchanged_o    (unch_s[g])
        );
    end

    // Sequencer state and delay counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cntr_q  <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
        end
    end

    // Next-state: disabling the monitor always parks it in IDLE.
    always_comb begin
        state_d = state_q;
        cntr_d  = cntr_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cntr_d  = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE:  state_d = dbginit_i ? ST_INIT : ST_IDLE;
                ST_INIT: begin
                    if (!dbginit_i) begin
                        state_d = ST_COUNT;
                        cntr_d  = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_INIT;
                    end
                end
                ST_COUNT: begin
                    if (dbginit_i) begin
                        state_d = ST_INIT;
                    end else if (cntr_q == cnt_val_i) begin
                        state_d = ST_DONE;
                    end else begin
                        cntr_d = cntr_q + CNT_W'(1);
                    end
                end
                ST_DONE:  state_d = dbginit_i ? ST_INIT : ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Shared strobes to the channel checkers and result logic.
    always_comb begin
        latch_pre_s    = 1'b0;
        clr_seen_s     = 1'b0;
        count_active_s = 1'b0;
        check_s        = 1'b0;
        leave_done_s   = 1'b0;
        case (state_q)
            ST_IDLE:  latch_pre_s = enable_i & dbginit_i;
            ST_INIT:  clr_seen_s  = enable_i & ~dbginit_i;
            ST_COUNT: begin
                count_active_s = 1'b1;
                latch_pre_s    = enable_i & dbginit_i;
                check_s        = enable_i & ~dbginit_i & (cntr_q == cnt_val_i);
            end
            ST_DONE: begin
                latch_pre_s  = enable_i & dbginit_i;
                leave_done_s = enable_i & dbginit_i;
            end
            default:  latch_pre_s = 1'b0;
        endcase
    end

    // Lowest failing channel of the current check.
    always_comb begin
        low_idx_s = {IDX_W{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            low_idx_s = fail_s[i] ? IDX_W'(i) : low_idx_s;
        end
    end

    assign err_next_s = ERR_W'(sat_add32(32'(err_q), 32'(popcount32(32'(fail_s))), ERR_MAX32));

    // Round results; first-fail capture is only armed until the first failure.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_vec_q   <= {NCH{1'b0}};
            unch_q       <= {NCH{1'b0}};
            fail_pulse_q <= 1'b0;
            ffv_q        <= 1'b0;
            ffi_q        <= {IDX_W{1'b0}};
            err_q        <= {ERR_W{1'b0}};
        end else begin
            fail_pulse_q <= 1'b0;
            if (check_s) begin
                done_q       <= 1'b1;
                pass_q       <= ~|fail_s;
                fail_vec_q   <= fail_s;
                unch_q       <= unch_s;
                fail_pulse_q <= |fail_s;
                err_q        <= err_next_s;
                if (!ffv_q && (|fail_s)) begin
                    ffv_q <= 1'b1;
                    ffi_q <= low_idx_s;
                end
            end else if (leave_done_s) begin
                done_q     <= 1'b0;
                pass_q     <= 1'b0;
                fail_vec_q <= {NCH{1'b0}};
            end
        end
    end

    assign done_o             = done_q;
    assign pass_o             = pass_q;
    assign fail_vec_o         = fail_vec_q;
    assign unchanged_vec_o    = unch_q;
    assign fail_pulse_o       = fail_pulse_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_idx_o   = ffi_q;
    assign err_cnt_o          = err_q;

endmodule
